rot_addr_gen: RTL and testbench

ROT_ADDR_GEN -- requirements
Module: rot_addr_gen

---
 rtl/rot_pkg.sv | 15 +
 rtl/rot_addr_map.sv | 38 +++
 rtl/rot_addr_gen.sv | 126 ++++++++++++
 tb/tb_rot_addr_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared types for the tiled rotation address generator: FSM states, rotation codes, defaults.
package rot_pkg;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_t;
  typedef enum logic [1:0] {DEG_0 = 2'd0, DEG_90 = 2'd1, DEG_180 = 2'd2, DEG_270 = 2'd3} deg_t;

  localparam int TILE_DEF = 8;
  localparam int BPP_DEF  = 3;

  // Counter-clockwise by d equals clockwise by (4-d) mod 4, i.e. two's-complement negation in 2 bits.
  function automatic deg_t eff_rot(input logic [1:0] deg, input logic cw);
    return cw ? deg_t'(deg) : deg_t'(2'd0 - deg);
  endfunction

endpackage

// File: rtl/rot_addr_map.sv
// Combinational destination-address mapping of a source pixel (y,x) for a given effective rotation.
module rot_addr_map import rot_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int BPP    = BPP_DEF
) (
  input  logic [ADDR_W-1:0] y,
  input  logic [ADDR_W-1:0] x,
  input  logic [ADDR_W-1:0] hp,
  input  logic [ADDR_W-1:0] wp,
  input  logic [ADDR_W-1:0] dst,
  input  deg_t              rot,
  input  logic              mirror,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] xm, oy, ox, stride;

  always_comb begin
    xm     = mirror ? (wp - x - ADDR_W'(1)) : x;
    oy     = y;
    ox     = xm;
    stride = wp;
    case (rot)
      DEG_90: begin
        oy = xm; ox = hp - y - ADDR_W'(1); stride = hp;
      end
      DEG_180: begin
        oy = hp - y - ADDR_W'(1); ox = wp - xm - ADDR_W'(1); stride = wp;
      end
      DEG_270: begin
        oy = wp - xm - ADDR_W'(1); ox = y; stride = hp;
      end
      default: ;
    endcase
    addr = dst + (oy * stride + ox) * ADDR_W'(BPP);
  end

endmodule

// File: rtl/rot_addr_gen.sv
// Tiled image-rotation DMA address generator: per tile, TILE*TILE reads then TILE*TILE rotated writes.
// Optional ROT_MIRROR_EN adds I_MIRROR (horizontal flip applied before rotation).
module rot_addr_gen import rot_pkg::*; #(
  parameter int TILE    = TILE_DEF,
  parameter int BPP     = BPP_DEF,
  parameter int ADDR_W  = 32,
  parameter int DIM_W   = 16,
  parameter int MAX_DIM = 16383
) (
  input  logic                            I_HCLK,
  input  logic                            I_HRESET_N,
  input  logic                            I_START,
  input  logic [DIM_W-1:0]                I_HEIGHT,
  input  logic [DIM_W-1:0]                I_WIDTH,
  input  logic [ADDR_W-1:0]               I_SRC_BASE,
  input  logic [ADDR_W-1:0]               I_DST_BASE,
  input  logic [1:0]                      I_DEGREES,
  input  logic                            I_DIRECTION,
`ifdef ROT_MIRROR_EN
  input  logic                            I_MIRROR,
`endif
  input  logic                            I_DMA_READY,
  output logic [ADDR_W-1:0]               O_ADDR,
  output logic [2:0]                      O_SIZE,
  output logic                            O_WRITE,
  output logic                            O_VALID,
  output logic [$clog2(TILE*TILE)-1:0]    O_COUNT,
  output logic                            O_BUSY,
  output logic                            O_DONE,
  output logic                            O_ERR
);

  localparam int LOG_T = $clog2(TILE);
  localparam int CNT_W = 2 * LOG_T;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   k;
  logic [DIM_W-1:0]   ty, tx, hp, wp, nty, ntx, hp_in, wp_in;
  logic [ADDR_W-1:0]  src, dst, y, x, raddr, waddr;
  logic [LOG_T-1:0]   r, c;
  deg_t               rot;
  logic               mirror, legal, go, accept, k_last, ty_last, last_tile;

  assign legal = (I_HEIGHT != '0) && (I_HEIGHT <= DIM_W'(MAX_DIM)) &&
                 (I_WIDTH  != '0) && (I_WIDTH  <= DIM_W'(MAX_DIM));
  // Round up to a tile multiple; only latched when legal, so the add cannot wrap.
  assign hp_in = (I_HEIGHT + DIM_W'(TILE-1)) & ~DIM_W'(TILE-1);
  assign wp_in = (I_WIDTH  + DIM_W'(TILE-1)) & ~DIM_W'(TILE-1);

  assign go        = (state == S_IDLE) && I_START && legal;
  assign accept    = O_VALID && I_DMA_READY;
  assign k_last    = &k;
  assign nty       = hp >> LOG_T;
  assign ntx       = wp >> LOG_T;
  assign ty_last   = (ty == nty - DIM_W'(1));
  assign last_tile = ty_last && (tx == ntx - DIM_W'(1));

  assign r     = k[CNT_W-1:LOG_T];
  assign c     = k[LOG_T-1:0];
  assign y     = (ADDR_W'(ty) << LOG_T) | ADDR_W'(r);
  assign x     = (ADDR_W'(tx) << LOG_T) | ADDR_W'(c);
  assign raddr = src + (y * ADDR_W'(wp) + x) * ADDR_W'(BPP);

  rot_addr_map #(.ADDR_W(ADDR_W), .BPP(BPP)) u_map (
    .y(y), .x(x), .hp(ADDR_W'(hp)), .wp(ADDR_W'(wp)), .dst(dst),
    .rot(rot), .mirror(mirror), .addr(waddr)
  );

  always_ff @(posedge I_HCLK or negedge I_HRESET_N)
    if (!I_HRESET_N) state <= S_IDLE;
    else             state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (go) state_nx = S_READ;
      S_READ:  if (accept && k_last) state_nx = S_WRITE;
      S_WRITE: if (accept && k_last) state_nx = last_tile ? S_IDLE : S_READ;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge I_HCLK or negedge I_HRESET_N)
    if (!I_HRESET_N) begin
      k <= '0; ty <= '0; tx <= '0; hp <= '0; wp <= '0;
      src <= '0; dst <= '0; rot <= DEG_0;
      O_DONE <= 1'b0; O_ERR <= 1'b0;
    end else begin
      O_DONE <= 1'b0;
      O_ERR  <= (state == S_IDLE) && I_START && !legal;
      if (go) begin
        k <= '0; ty <= '0; tx <= '0;
        hp <= hp_in; wp <= wp_in;
        src <= I_SRC_BASE; dst <= I_DST_BASE;
        rot <= eff_rot(I_DEGREES, I_DIRECTION);
      end else if (accept) begin
        k <= k + 1'b1;
        // Tile rows advance fastest; column steps when the row index wraps.
        if (state == S_WRITE && k_last) begin
          if (last_tile) begin
            ty <= '0; tx <= '0; O_DONE <= 1'b1;
          end else if (ty_last) begin
            ty <= '0; tx <= tx + DIM_W'(1);
          end else begin
            ty <= ty + DIM_W'(1);
          end
        end
      end
    end

`ifdef ROT_MIRROR_EN
  always_ff @(posedge I_HCLK or negedge I_HRESET_N)
    if (!I_HRESET_N) mirror <= 1'b0;
    else if (go)     mirror <= I_MIRROR;
`else
  assign mirror = 1'b0;
`endif

  assign O_VALID = (state != S_IDLE);
  assign O_BUSY  = (state != S_IDLE);
  assign O_WRITE = (state == S_WRITE);
  assign O_COUNT = k;
  assign O_SIZE  = 3'(BPP - 1);
  assign O_ADDR  = !O_VALID ? '0 : (O_WRITE ? waddr : raddr);

endmodule

// File: tb/tb_rot_addr_gen.sv
// Scoreboard bench for rot_addr_gen: stimulus pushes expected beats, a monitor pops on each accepted beat.
module tb_rot_addr_gen;
  localparam int TILE = 8, BPP = 3, AW = 32, DW = 16;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, dir = 1'b1, ready = 1'b1;
  logic [DW-1:0] height = 16'd8, width = 16'd8;
  logic [AW-1:0] src_b = '0, dst_b = '0;
  logic [1:0]    deg = 2'd0;
  logic [AW-1:0] o_addr;
  logic [2:0]    o_size;
  logic [5:0]    o_count;
  logic          o_write, o_valid, o_busy, o_done, o_err;

  rot_addr_gen #(.TILE(TILE), .BPP(BPP), .ADDR_W(AW), .DIM_W(DW), .MAX_DIM(16383)) dut (
    .I_HCLK(clk), .I_HRESET_N(rst_n), .I_START(start), .I_HEIGHT(height), .I_WIDTH(width),
    .I_SRC_BASE(src_b), .I_DST_BASE(dst_b), .I_DEGREES(deg), .I_DIRECTION(dir),
`ifdef ROT_MIRROR_EN
    .I_MIRROR(1'b0),
`endif
    .I_DMA_READY(ready), .O_ADDR(o_addr), .O_SIZE(o_size), .O_WRITE(o_write),
    .O_VALID(o_valid), .O_COUNT(o_count), .O_BUSY(o_busy), .O_DONE(o_done), .O_ERR(o_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [31:0] addr; int cnt; } beat_t;
  beat_t       q[$];
  int          checks = 0, errors = 0;
  bit          rand_rdy = 1'b0;
  int          run_len = 0, rd_n = 0, wr_n = 0;
  bit          run_wr = 1'b0, seen_wr = 1'b0, prev_busy = 1'b0, hold = 1'b0;
  logic [38:0] held;
  logic [31:0] first_wr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(bit wr, int y, int x, int hp, int wp, int e,
                                        logic [31:0] s, logic [31:0] d);
    int oy, ox, st;
    if (!wr) return s + 32'((y * wp + x) * BPP);
    case (e)
      1:       begin oy = x;          ox = hp - 1 - y; st = hp; end
      2:       begin oy = hp - 1 - y; ox = wp - 1 - x; st = wp; end
      3:       begin oy = wp - 1 - x; ox = y;          st = hp; end
      default: begin oy = y;          ox = x;          st = wp; end
    endcase
    return d + 32'((oy * st + ox) * BPP);
  endfunction

  task automatic push_job(input int h, input int w, input logic [31:0] s, input logic [31:0] d, input int e);
    int hp, wp;
    hp = ((h + TILE - 1) / TILE) * TILE;
    wp = ((w + TILE - 1) / TILE) * TILE;
    for (int tx = 0; tx < wp / TILE; tx++)
      for (int ty = 0; ty < hp / TILE; ty++)
        for (int ph = 0; ph < 2; ph++)
          for (int k = 0; k < TILE * TILE; k++)
            q.push_back('{bit'(ph), model(bit'(ph), ty*TILE + k/TILE, tx*TILE + k%TILE, hp, wp, e, s, d), k});
  endtask

  // Launches a job and waits for O_DONE; cyc counts edges after the start-sampling edge.
  task automatic run_job(input int h, input int w, input logic [31:0] s, input logic [31:0] d,
                         input logic [1:0] dg, input logic dr, input int e, output int cyc);
    height = DW'(h); width = DW'(w); src_b = s; dst_b = d; deg = dg; dir = dr;
    push_job(h, w, s, d, e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    deg = ~dg; dir = ~dr;
    cyc = 0;
    while (!o_done && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!o_done) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=%0d required=done", cyc);
    end
    @(posedge clk); #1;
    check("done_pulse_width", o_done, 1'b0);
    check("idle_after_done", o_busy, 1'b0);
    check("queue_drained", q.size(), 0);
    check("last_tile_run", run_len, TILE * TILE);
  endtask

  initial forever begin
    @(posedge clk); #1;
    ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops on every accepted beat, checks hold-while-stalled and per-phase beat counts.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q.delete(); run_len = 0; prev_busy = 1'b0; hold = 1'b0;
    end else begin
      if (o_busy && !prev_busy) begin run_len = 0; run_wr = 1'b0; seen_wr = 1'b0; end
      prev_busy = o_busy;
      if (hold) check("stall_hold", {o_write, o_count, o_addr}, held);
      hold = o_valid && !ready;
      held = {o_write, o_count, o_addr};
      if (o_valid && ready) begin
        if (o_write != run_wr && run_len > 0) begin
          check("tile_run", run_len, TILE * TILE);
          run_len = 0;
        end
        run_wr = o_write;
        run_len++;
        if (o_write && !seen_wr) begin first_wr = o_addr; seen_wr = 1'b1; end
        if (o_write) wr_n++; else rd_n++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected actual=%0h required=none", o_addr);
        end else begin
          beat_t e;
          e = q.pop_front();
          check("beat", {o_write, o_count, o_addr}, {e.wr, 6'(e.cnt), e.addr});
        end
      end
    end
  end

  initial begin
    int cyc, rd0, wr0;
    #12;
    check("rst_valid", o_valid, 1'b0);
    check("rst_addr", o_addr, 32'h0);
    check("rst_size", o_size, 3'd2);
    check("rst_busy_cnt", {o_busy, o_done, o_err, o_write, o_count}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 8x8, no rotation: contiguous reads/writes, done 128 edges after start sampling.
    run_job(8, 8, 32'h1000, 32'h8000, 2'd0, 1'b1, 0, cyc);
    check("done_cycle_8x8", cyc, 128);
    check("first_wr_e0", first_wr, 32'h8000);

    // 16x8 CW 90: source (0,0) lands at (0*16+15)*3 = 45.
    run_job(16, 8, 32'h100, 32'h0, 2'd1, 1'b1, 1, cyc);
    check("first_wr_cw90", first_wr, 32'd45);
    // CW 270 and CCW 90 both place source (0,0) at (7*16+0)*3 = 336.
    run_job(16, 8, 32'h100, 32'h0, 2'd3, 1'b1, 3, cyc);
    check("first_wr_cw270", first_wr, 32'd336);
    run_job(16, 8, 32'h100, 32'h0, 2'd1, 1'b0, 3, cyc);
    check("first_wr_ccw90", first_wr, 32'd336);

    // 1x1 pads to one full tile; CW 90 puts (0,0) at 0x400 + 7*3.
    run_job(1, 1, 32'h0, 32'h400, 2'd1, 1'b1, 1, cyc);
    check("done_cycle_1x1", cyc, 128);
    check("first_wr_1x1", first_wr, 32'h415);

    // Random stalls on a padded 10x12 image (4 tiles), CCW 180.
    rand_rdy = 1'b1;
    rd0 = rd_n; wr0 = wr_n;
    run_job(10, 12, 32'h40, 32'h9000, 2'd2, 1'b0, 2, cyc);
    check("rand_reads", rd_n - rd0, 256);
    check("rand_writes", wr_n - wr0, 256);
    rand_rdy = 1'b0;
    @(posedge clk); #1;

    // Illegal width: one-cycle error, never busy.
    height = 16'd8; width = 16'd16384; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("err_pulse", {o_err, o_busy}, 2'b10);
    @(posedge clk); #1;
    check("err_cleared", {o_err, o_busy}, 2'b00);

    // Reset at read beat 20, then a fresh job.
    height = 16'd8; width = 16'd8; src_b = 32'h1000; dst_b = 32'h8000; deg = 2'd0; dir = 1'b1;
    push_job(8, 8, 32'h1000, 32'h8000, 0);
    rd0 = rd_n;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (rd_n - rd0 < 20 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("pre_reset_count", o_count, 6'd20);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_addr", o_addr, 32'h0);
    check("rst_mid_size", o_size, 3'd2);
    check("rst_mid_flags", {o_valid, o_busy, o_done, o_err, o_write, o_count}, '0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(8, 8, 32'h2000, 32'h3000, 2'd0, 1'b0, 0, cyc);
    check("done_cycle_after_rst", cyc, 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
